// File: rtl/rb_ctrl.sv
// Row-buffer sequencing controller: steps column/row/bank counters on each
// accepted pixel and flags when the BRAM outputs plus the incoming pixel form a full column.
module rb_ctrl #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ROWS   = 5,
    parameter int ADDR_W = 9,
    parameter int ROW_W  = 9,
    localparam int NB    = ROWS - 1,
    localparam int SEL_W = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [NB-1:0]     bram_we,
    output logic [SEL_W-1:0]  rot_sel,
    output logic              win_valid,
    output logic [ROW_W-1:0]  win_row,
    output logic [ADDR_W-1:0] win_col,
    output logic              complete
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0]  ROW_WIN   = ROW_W'(ROWS - 1);
    localparam logic [SEL_W-1:0]  BANK_LAST = SEL_W'(NB - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [SEL_W-1:0]   bank_q, bank_d;
    logic               win_valid_q, win_valid_d;
    logic [SEL_W-1:0]   rot_q, rot_d;
    logic [ROW_W-1:0]   win_row_q, win_row_d;
    logic [ADDR_W-1:0]  win_col_q, win_col_d;
    logic               accept;

    assign accept = pix_valid && (state_q == RUN);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                    bank_d  = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                        // explicit wrap: bank count need not be a power of two
                        bank_d = (bank_q == BANK_LAST) ? '0 : bank_q + SEL_W'(1);
                        if (row_q == ROW_LAST) begin
                            state_d = DONE;
                        end
                    end else begin
                        col_d = col_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        win_valid_d = accept && (row_q >= ROW_WIN);
        rot_d       = rot_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (win_valid_d) begin
            rot_d     = bank_q;
            win_row_d = row_q;
            win_col_d = col_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            bank_q      <= '0;
            win_valid_q <= 1'b0;
            rot_q       <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bank_q      <= bank_d;
            win_valid_q <= win_valid_d;
            rot_q       <= rot_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign pix_ready = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign complete  = (state_q == DONE);
    assign bram_addr = col_q;
    assign bram_we   = accept ? (NB'(1) << bank_q) : '0;
    assign win_valid = win_valid_q;
    assign rot_sel   = rot_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;

endmodule

// File: tb/tb_rb_ctrl.sv
// Scoreboard bench for rb_ctrl: an 8x6/ROWS=5 instance and a 4x4/ROWS=3 instance.
`timescale 1ns/1ps
module tb_rb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_a, pv_a, start_b, pv_b;
    logic       ready_a, busy_a, wv_a, cmp_a;
    logic [8:0] addr_a, wrow_a, wcol_a;
    logic [3:0] we_a;
    logic [1:0] rot_a;
    logic       ready_b, busy_b, wv_b, cmp_b;
    logic [1:0] addr_b, wrow_b, wcol_b, we_b;
    logic [0:0] rot_b;

    rb_ctrl #(.IMG_W(8), .IMG_H(6), .ROWS(5), .ADDR_W(9), .ROW_W(9)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pix_valid(pv_a),
        .pix_ready(ready_a), .busy(busy_a), .bram_addr(addr_a), .bram_we(we_a),
        .rot_sel(rot_a), .win_valid(wv_a), .win_row(wrow_a), .win_col(wcol_a),
        .complete(cmp_a)
    );

    rb_ctrl #(.IMG_W(4), .IMG_H(4), .ROWS(3), .ADDR_W(2), .ROW_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pix_valid(pv_b),
        .pix_ready(ready_b), .busy(busy_b), .bram_addr(addr_b), .bram_we(we_b),
        .rot_sel(rot_b), .win_valid(wv_b), .win_row(wrow_b), .win_col(wcol_b),
        .complete(cmp_b)
    );

    typedef struct {
        int row;
        int col;
        int bank;
    } exp_t;

    exp_t   qa[$];
    exp_t   qb[$];
    exp_t   ma, mb;
    int     checks = 0;
    int     errors = 0;
    int     win_cnt_a, cmp_cnt_a, win_cnt_b, cmp_cnt_b;
    longint first_win_t;
    int     bank_tab_a[6] = '{0, 1, 2, 3, 0, 1};
    int     bank_tab_b[4] = '{0, 1, 0, 1};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wv_a) begin
            win_cnt_a++;
            if (first_win_t == 0) first_win_t = $time;
            chk("win_a_pending", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                ma = qa.pop_front();
                chk("win_row_a", 32'(wrow_a), ma.row);
                chk("win_col_a", 32'(wcol_a), ma.col);
                chk("rot_sel_a", 32'(rot_a), ma.bank);
            end
        end
        if (cmp_a) begin
            cmp_cnt_a++;
            chk("complete_with_last_win_a", 32'(wv_a), 1);
        end
    end

    always @(negedge clk) begin
        if (wv_b) begin
            win_cnt_b++;
            chk("win_b_pending", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                mb = qb.pop_front();
                chk("win_row_b", 32'(wrow_b), mb.row);
                chk("win_col_b", 32'(wcol_b), mb.col);
                chk("rot_sel_b", 32'(rot_b), mb.bank);
            end
        end
        if (cmp_b) begin
            cmp_cnt_b++;
            chk("complete_with_last_win_b", 32'(wv_b), 1);
        end
    end

    // mode 0 full rate, 1 valid pattern 1,0,0, 2 start re-pulsed at col 3, 3 stop mid-row 4
    task automatic run_a(input int mode);
        int     acc = 0;
        int     cyc = 0;
        int     r = 0;
        int     c = 0;
        longint p0;
        exp_t   e;
        win_cnt_a = 0;
        cmp_cnt_a = 0;
        first_win_t = 0;
        start_a = 1'b1;
        @(posedge clk);
        p0 = $time;
        #1 start_a = 1'b0;
        while (acc < 48 && cyc < 2000) begin
            if (mode == 3 && r == 4 && c == 3) break;
            pv_a    = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            start_a = (mode == 2 && r == 0 && c == 3);
            @(negedge clk);
            chk("ready_run_a", 32'(ready_a), 1);
            chk("busy_run_a", 32'(busy_a), 1);
            if (pv_a) begin
                chk("bram_we_a", 32'(we_a), 1 << bank_tab_a[r]);
                chk("bram_addr_a", 32'(addr_a), c);
                if (r >= 4) begin
                    e.row = r; e.col = c; e.bank = bank_tab_a[r];
                    qa.push_back(e);
                end
                acc++;
                if (c == 7) begin c = 0; r++; end else c++;
            end else begin
                chk("bram_we_idle_a", 32'(we_a), 0);
                chk("bram_addr_hold_a", 32'(addr_a), c);
            end
            @(posedge clk);
            #1 cyc++;
        end
        pv_a = 1'b0;
        start_a = 1'b0;
        if (mode != 3) begin
            chk("accepts_a", acc, 48);
            @(negedge clk);
            chk("complete_pulse_a", 32'(cmp_a), 1);
            chk("busy_done_a", 32'(busy_a), 1);
            chk("ready_done_a", 32'(ready_a), 0);
            @(posedge clk);
            @(negedge clk);
            chk("complete_clear_a", 32'(cmp_a), 0);
            chk("busy_idle_a", 32'(busy_a), 0);
            chk("win_count_a", win_cnt_a, 16);
            chk("complete_count_a", cmp_cnt_a, 1);
            chk("queue_drained_a", qa.size(), 0);
            if (mode == 0) chk("first_win_delay_a", 32'((first_win_t - 5 - p0) / 10), 33);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_b();
        int   acc = 0;
        int   cyc = 0;
        int   r = 0;
        int   c = 0;
        exp_t e;
        win_cnt_b = 0;
        cmp_cnt_b = 0;
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        while (acc < 16 && cyc < 200) begin
            pv_b = 1'b1;
            @(negedge clk);
            chk("ready_run_b", 32'(ready_b), 1);
            chk("bram_we_b", 32'(we_b), 1 << bank_tab_b[r]);
            chk("bram_addr_b", 32'(addr_b), c);
            if (r >= 2) begin
                e.row = r; e.col = c; e.bank = bank_tab_b[r];
                qb.push_back(e);
            end
            acc++;
            if (c == 3) begin c = 0; r++; end else c++;
            @(posedge clk);
            #1 cyc++;
        end
        pv_b = 1'b0;
        chk("accepts_b", acc, 16);
        @(negedge clk);
        chk("complete_pulse_b", 32'(cmp_b), 1);
        @(posedge clk);
        @(negedge clk);
        chk("busy_idle_b", 32'(busy_b), 0);
        chk("win_count_b", win_cnt_b, 8);
        chk("complete_count_b", cmp_cnt_b, 1);
        chk("queue_drained_b", qb.size(), 0);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({"ready_", tag}, 32'(ready_a), 0);
        chk({"busy_", tag}, 32'(busy_a), 0);
        chk({"we_", tag}, 32'(we_a), 0);
        chk({"win_valid_", tag}, 32'(wv_a), 0);
        chk({"complete_", tag}, 32'(cmp_a), 0);
        chk({"addr_", tag}, 32'(addr_a), 0);
        chk({"rot_", tag}, 32'(rot_a), 0);
        chk({"win_row_", tag}, 32'(wrow_a), 0);
        chk({"win_col_", tag}, 32'(wcol_a), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; pv_a = 1'b0;
        start_b = 1'b0; pv_b = 1'b0;
        #12;
        chk_zero_a("reset_a");
        chk("ready_reset_b", 32'(ready_b), 0);
        chk("win_valid_reset_b", 32'(wv_b), 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_a(0);
        run_a(1);
        run_a(2);
        run_a(0);

        run_a(3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero_a("async_reset_a");
        repeat (3) @(negedge clk);
        chk("no_complete_on_reset_a", cmp_cnt_a, 0);
        qa.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_a(0);

        run_b();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
